// File: rtl/dnoc_itf_core_rd.sv
// dnoc_itf_core_rd
// Core-side read engine. A command reads either from the NoC (beats stream
// straight through to the core) or from local L2 memory. An L2 read walks
// one ping or pong buffer, with the returns staged in a small FIFO.
// Requests are credit limited, so every in-flight return always has a FIFO
// slot waiting for it. In ping-pong mode the engine alternates between the
// two buffers until the configured number of pairs has been read.

module dnoc_itf_core_rd #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  // command handshake
  input  logic             core_cmd_core_rd_req,
  output logic             core_cmd_core_rd_gnt,
  // configuration
  input  logic [1:0][12:0] c_cfg_c_r_base_addr,
  input  logic [12:0]      c_cfg_c_r_ping_lenth,
  input  logic [12:0]      c_cfg_c_r_pong_lenth,
  input  logic             c_cfg_c_r_pingpong_en,
  input  logic [10:0]      c_cfg_c_r_pingpong_num,
  input  logic             c_cfg_c_r_local_access,
  // ping-pong buffer status / completion
  input  logic [1:0]       pingpong_state,
  output logic             pingpong_rd_done,
  output logic             c_r_transaction_done,
  // stream to core
  output logic [255:0]     core_in_data,
  output logic             core_in_valid,
  input  logic             core_in_ready,
  // NoC read request and return stream
  output logic             core_rd_noc_out_req,
  input  logic             core_rd_noc_out_gnt,
  input  logic [255:0]     noc_in_core_rd_data,
  input  logic             noc_in_core_rd_valid,
  input  logic             noc_in_core_rd_last,
  output logic             noc_in_core_rd_ready,
  // L2 read port
  output logic             L2_dmem_core_rd_req,
  input  logic             L2_dmem_core_rd_gnt,
  output logic [12:0]      L2_dmem_core_rd_addr,
  input  logic [255:0]     L2_dmem_core_rd_data,
  input  logic             L2_dmem_core_rd_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_NOC_RD_REQ     = 3'd1,
    S_NOC_RD         = 3'd2,
    S_PINGPONG_CHECK = 3'd3,
    S_PING_RD        = 3'd4,
    S_PONG_RD        = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [13:0]      issued_q, issued_d;       // L2 requests granted this buffer
  logic [13:0]      accepted_q, accepted_d;   // words taken by the core this buffer
  logic [12:0]      noc_beat_q, noc_beat_d;   // NoC beats passed through
  logic [11:0]      pp_cnt_q, pp_cnt_d;       // buffers started in this command
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [255:0]     fifo_mem [FIFO_DEPTH];

  logic             in_local;
  logic             rd_sel;
  logic [12:0]      cur_lenth;
  logic             fifo_empty;
  logic             credit_ok;
  logic             l2_req_c;
  logic [12:0]      l2_addr_c;
  logic             issue;
  logic             push;
  logic             pop;

  // Buffer selection and the credit rule for L2 requests.
  assign in_local   = (state_q == S_PING_RD) || (state_q == S_PONG_RD);
  assign rd_sel     = (state_q == S_PONG_RD);
  assign cur_lenth  = rd_sel ? c_cfg_c_r_pong_lenth : c_cfg_c_r_ping_lenth;
  assign fifo_empty = (fifo_cnt_q == '0);
  // A request is allowed only if a FIFO slot is reserved for its return.
  assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH;
  assign l2_req_c   = in_local && (issued_q <= {1'b0, cur_lenth}) && credit_ok;
  assign l2_addr_c  = c_cfg_c_r_base_addr[rd_sel] + issued_q[12:0];
  assign issue      = l2_req_c && L2_dmem_core_rd_gnt;
  // Returns with nothing outstanding belong to a transfer killed by reset.
  assign push       = L2_dmem_core_rd_valid && (outstanding_q != '0);
  assign pop        = in_local && !fifo_empty && core_in_ready;

  // Next-state logic and state-dependent outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d               = state_q;
    issued_d              = issued_q;
    accepted_d            = accepted_q;
    noc_beat_d            = noc_beat_q;
    pp_cnt_d              = pp_cnt_q;
    core_cmd_core_rd_gnt  = 1'b0;
    pingpong_rd_done      = 1'b0;
    c_r_transaction_done  = 1'b0;
    core_in_valid         = 1'b0;
    core_rd_noc_out_req   = 1'b0;
    noc_in_core_rd_ready  = 1'b0;
    L2_dmem_core_rd_req   = 1'b0;
    L2_dmem_core_rd_addr  = '0;
    core_in_data          = fifo_mem[rd_ptr_q];

    unique case (state_q)
      S_IDLE: begin
        if (core_cmd_core_rd_req) begin
          if (c_cfg_c_r_local_access) begin
            core_cmd_core_rd_gnt = 1'b1;
            issued_d             = '0;
            accepted_d           = '0;
            noc_beat_d           = '0;
            pp_cnt_d             = 12'd1;
            state_d              = S_PING_RD;
          end else begin
            state_d = S_NOC_RD_REQ;
          end
        end
      end

      S_NOC_RD_REQ: begin
        core_rd_noc_out_req = 1'b1;
        if (core_rd_noc_out_gnt) begin
          core_cmd_core_rd_gnt = 1'b1;
          noc_beat_d           = '0;
          state_d              = S_NOC_RD;
        end
      end

      S_NOC_RD: begin
        core_in_data         = noc_in_core_rd_data;
        core_in_valid        = noc_in_core_rd_valid;
        noc_in_core_rd_ready = core_in_ready;
        if (noc_in_core_rd_valid && core_in_ready) begin
          if ((noc_beat_q == c_cfg_c_r_ping_lenth) || noc_in_core_rd_last) begin
            c_r_transaction_done = 1'b1;
            noc_beat_d           = '0;
            state_d              = S_IDLE;
          end else begin
            noc_beat_d = noc_beat_q + 13'd1;
          end
        end
      end

      S_PING_RD, S_PONG_RD: begin
        L2_dmem_core_rd_req  = l2_req_c;
        L2_dmem_core_rd_addr = l2_addr_c;
        core_in_valid        = !fifo_empty;
        if (issue) begin
          issued_d = issued_q + 14'd1;
        end
        if (pop) begin
          if (accepted_q == {1'b0, cur_lenth}) begin
            pingpong_rd_done = c_cfg_c_r_pingpong_en;
            issued_d         = '0;
            accepted_d       = '0;
            if (c_cfg_c_r_pingpong_en) begin
              state_d = S_PINGPONG_CHECK;
            end else begin
              c_r_transaction_done = 1'b1;
              state_d              = S_IDLE;
            end
          end else begin
            accepted_d = accepted_q + 14'd1;
          end
        end
      end

      S_PINGPONG_CHECK: begin
        if (pp_cnt_q[11:1] == c_cfg_c_r_pingpong_num) begin
          c_r_transaction_done = 1'b1;
          pp_cnt_d             = '0;
          state_d              = S_IDLE;
        end else if (core_cmd_core_rd_req) begin
          if (pp_cnt_q[0] && pingpong_state[1]) begin
            core_cmd_core_rd_gnt = 1'b1;
            pp_cnt_d             = pp_cnt_q + 12'd1;
            state_d              = S_PONG_RD;
          end else if (!pp_cnt_q[0] && pingpong_state[0]) begin
            core_cmd_core_rd_gnt = 1'b1;
            pp_cnt_d             = pp_cnt_q + 12'd1;
            state_d              = S_PING_RD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset silences every control output at once, before any clock edge.
    if (rst) begin
      core_cmd_core_rd_gnt = 1'b0;
      pingpong_rd_done     = 1'b0;
      c_r_transaction_done = 1'b0;
      core_in_valid        = 1'b0;
      core_rd_noc_out_req  = 1'b0;
      noc_in_core_rd_ready = 1'b0;
      L2_dmem_core_rd_req  = 1'b0;
      L2_dmem_core_rd_addr = '0;
    end
  end

  // Outstanding-request and FIFO occupancy/pointer bookkeeping.
  always_comb begin
    outstanding_d = outstanding_q;
    fifo_cnt_d    = fifo_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    unique case ({issue, push})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      issued_q      <= '0;
      accepted_q    <= '0;
      noc_beat_q    <= '0;
      pp_cnt_q      <= '0;
      outstanding_q <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      issued_q      <= issued_d;
      accepted_q    <= accepted_d;
      noc_beat_q    <= noc_beat_d;
      pp_cnt_q      <= pp_cnt_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage for L2 returns.
  // NOTE: the storage array has no reset; emptiness is tracked entirely by
  // the occupancy counter, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= L2_dmem_core_rd_data;
    end
  end

endmodule
